// File: rtl/operand2_encoder.sv
// Serial encoder: finds the smallest rotation whose {rot, imm8} field decodes to a 32-bit constant.
// Optional macro OPERAND2_NEGATE_SEARCH_EN also tests ~value at each rotation (MVN/BIC substitution).
module operand2_encoder #(
    parameter int ROT_STEPS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] valueIn,
    output logic        busy,
    output logic        done,
    output logic        encodable,
    output logic [11:0] data12Out,
    output logic        useInvert,
    output logic [1:0]  state_o
);

    // Handshake: start is sampled on a rising edge and accepted only while busy=0;
    // done is a one-cycle pulse, result outputs hold until the next accepted start.

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ROT = 4'(ROT_STEPS - 1);

    state_t      state_q, state_d;
    logic [3:0]  rot_q, rot_d;
    logic [31:0] value_q, value_d;
    logic        enc_q, enc_d;
    logic [11:0] data_q, data_d;
    logic        inv_q, inv_d;

    logic [5:0]  shamt;
    logic [31:0] cand_pos;
    logic        hit_pos;

    // Rotating left by 2r undoes the decode's rotate-right by 2r.
    function automatic logic [31:0] rotl(input logic [31:0] v, input logic [5:0] s);
        rotl = (v << s) | (v >> (6'd32 - s));
    endfunction

    assign shamt    = {rot_q, 1'b0};
    assign cand_pos = rotl(value_q, shamt);
    assign hit_pos  = (cand_pos[31:8] == 24'd0);

`ifdef OPERAND2_NEGATE_SEARCH_EN
    logic [31:0] cand_neg;
    logic        hit_neg;
    assign cand_neg = rotl(~value_q, shamt);
    assign hit_neg  = (cand_neg[31:8] == 24'd0);
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rot_q   <= 4'd0;
            value_q <= 32'd0;
            enc_q   <= 1'b0;
            data_q  <= 12'd0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            value_q <= value_d;
            enc_q   <= enc_d;
            data_q  <= data_d;
            inv_q   <= inv_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        value_d = value_q;
        enc_d   = enc_q;
        data_d  = data_q;
        inv_d   = inv_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SEARCH;
                    value_d = valueIn;
                    rot_d   = 4'd0;
                    enc_d   = 1'b0;
                    data_d  = 12'd0;
                    inv_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (hit_pos) begin
                    state_d = ST_DONE;
                    enc_d   = 1'b1;
                    data_d  = {rot_q, cand_pos[7:0]};
                    inv_d   = 1'b0;
`ifdef OPERAND2_NEGATE_SEARCH_EN
                end else if (hit_neg) begin
                    state_d = ST_DONE;
                    enc_d   = 1'b1;
                    data_d  = {rot_q, cand_neg[7:0]};
                    inv_d   = 1'b1;
`endif
                end else if (rot_q == LAST_ROT) begin
                    state_d = ST_DONE;
                    enc_d   = 1'b0;
                    data_d  = 12'd0;
                    inv_d   = 1'b0;
                end else begin
                    rot_d = rot_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are all decoded from registers
    always_comb begin
        busy      = (state_q == ST_SEARCH);
        done      = (state_q == ST_DONE);
        encodable = enc_q;
        data12Out = data_q;
        useInvert = inv_q;
        state_o   = state_q;
    end

endmodule
